// File: rtl/lcd_controller.sv
// DE-only RGB LCD timing generator with a deterministic x/y test pattern.
// Scans back porch, active region and front porch on both axes, frames back-to-back.
module lcd_controller #(
    parameter int unsigned HORIZONTAL_BACK_PORCH  = 46,
    parameter int unsigned HORIZONTAL_FRONT_PORCH = 210,
    parameter int unsigned VERTICAL_BACK_PORCH    = 23,
    parameter int unsigned VERTICAL_FRONT_PORCH   = 22,
    parameter int unsigned HORIZONTAL_DATA_WIDTH  = 800,
    parameter int unsigned VERTICAL_DATA_WIDTH    = 480
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       i_start,
    output logic       o_data_en,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue
);

    localparam int unsigned HTotal = HORIZONTAL_BACK_PORCH + HORIZONTAL_DATA_WIDTH +
                                     HORIZONTAL_FRONT_PORCH;
    localparam int unsigned VTotal = VERTICAL_BACK_PORCH + VERTICAL_DATA_WIDTH +
                                     VERTICAL_FRONT_PORCH;
    localparam int unsigned HCntW  = (HTotal > 1) ? $clog2(HTotal) : 1;
    localparam int unsigned VCntW  = (VTotal > 1) ? $clog2(VTotal) : 1;
    localparam int unsigned HActEnd = HORIZONTAL_BACK_PORCH + HORIZONTAL_DATA_WIDTH;
    localparam int unsigned VActEnd = VERTICAL_BACK_PORCH + VERTICAL_DATA_WIDTH;

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [HCntW-1:0] h_cnt_q, h_cnt_d;
    logic [VCntW-1:0] v_cnt_q, v_cnt_d;
    logic             h_last, v_last, h_act, v_act;
    logic [7:0]       x_lo, y_lo;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (i_start) state_d = StRun;
            StRun:  state_d = StRun;
        endcase
    end

    assign h_last = (32'(h_cnt_q) == HTotal - 1);
    assign v_last = (32'(v_cnt_q) == VTotal - 1);

    // Counters sit at zero throughout IDLE, so the start edge leaves them at (0,0).
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (state_q == StIdle) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (!h_last) begin
            h_cnt_d = h_cnt_q + HCntW'(1);
        end else begin
            h_cnt_d = '0;
            v_cnt_d = v_last ? '0 : v_cnt_q + VCntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_act = (32'(h_cnt_q) >= HORIZONTAL_BACK_PORCH) && (32'(h_cnt_q) < HActEnd);
    assign v_act = (32'(v_cnt_q) >= VERTICAL_BACK_PORCH) && (32'(v_cnt_q) < VActEnd);
    assign x_lo  = 8'(32'(h_cnt_q) - HORIZONTAL_BACK_PORCH);
    assign y_lo  = 8'(32'(v_cnt_q) - VERTICAL_BACK_PORCH);

    always_comb begin
        o_data_en = 1'b0;
        o_red     = 8'h00;
        o_green   = 8'h00;
        o_blue    = 8'h00;
        if (state_q == StRun && h_act && v_act) begin
            o_data_en = 1'b1;
            o_red     = x_lo;
            o_green   = y_lo;
            o_blue    = x_lo ^ y_lo;
        end
    end

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller: small-geometry instance plus a default-geometry instance.
module tb_lcd_controller;

    logic       clk = 1'b0;
    logic       aresetn, i_start;
    logic       de;
    logic [7:0] red, green, blue;
    logic       d_rst_n, d_start;
    logic       d_de;
    logic [7:0] d_red, d_green, d_blue;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    lcd_controller #(
        .HORIZONTAL_BACK_PORCH (10),
        .HORIZONTAL_FRONT_PORCH(20),
        .VERTICAL_BACK_PORCH   (10),
        .VERTICAL_FRONT_PORCH  (20),
        .HORIZONTAL_DATA_WIDTH (20),
        .VERTICAL_DATA_WIDTH   (20)
    ) u_dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .i_start  (i_start),
        .o_data_en(de),
        .o_red    (red),
        .o_green  (green),
        .o_blue   (blue)
    );

    lcd_controller u_dut_dflt (
        .clk      (clk),
        .aresetn  (d_rst_n),
        .i_start  (d_start),
        .o_data_en(d_de),
        .o_red    (d_red),
        .o_green  (d_green),
        .o_blue   (d_blue)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_de(input int unsigned k0, output int unsigned k);
        k = k0;
        while (!de && k < 3000) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int unsigned k, bad, total, starts, bad_start, bad_len, run;
        logic        prev;
        logic [23:0] pix_5_3, pix_19_19;

        aresetn = 1'b0; i_start = 1'b0;
        d_rst_n = 1'b0; d_start = 1'b0;
        tick();
        tick();
        check("reset_de", {31'b0, de}, 32'd0);
        check("reset_rgb", {8'b0, red, green, blue}, 32'h0);
        aresetn = 1'b1;
        d_rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (de || {red, green, blue} != 24'h0) bad++;
        end
        check("idle_quiet", bad, 32'd0);

        // Single-cycle start pulse; edge S samples it.
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_de(0, k);
        check("start_latency", k, 32'd510);
        check("pixel_0_0", {8'b0, red, green, blue}, 32'h000000);

        // Frame 1 from its first DE cycle, with a stray start pulse mid-frame.
        prev = 1'b0; total = 0; starts = 0; bad_start = 0; bad_len = 0; run = 0;
        pix_5_3 = '0; pix_19_19 = '0;
        for (int c = 0; c < 2500; c++) begin
            if (de && !prev) begin
                starts++;
                if (c % 50 != 0) bad_start++;
                run = 0;
            end
            if (de) begin
                run++;
                total++;
            end
            if (!de && prev && run != 20) bad_len++;
            if (c == 155) pix_5_3 = {red, green, blue};
            if (c == 969) pix_19_19 = {red, green, blue};
            if (c == 700) i_start = 1'b1;
            if (c == 703) i_start = 1'b0;
            prev = de;
            tick();
        end
        check("frame1_de_count", total, 32'd400);
        check("frame1_bursts", starts, 32'd20);
        check("burst_spacing", bad_start, 32'd0);
        check("burst_length", bad_len, 32'd0);
        check("pixel_5_3", {8'b0, pix_5_3}, 32'h050306);
        check("pixel_19_19", {8'b0, pix_19_19}, 32'h131300);
        check("frame2_start_de", {31'b0, de}, 32'd1);
        check("frame2_start_rgb", {8'b0, red, green, blue}, 32'h0);

        total = 0;
        for (int c = 0; c < 2500; c++) begin
            if (de) total++;
            tick();
        end
        check("frame2_de_count", total, 32'd400);
        check("frame3_start_de", {31'b0, de}, 32'd1);

        // Mid-frame reset at pixel (7,4), with start asserted on the reset edge.
        repeat (207) tick();
        check("pixel_7_4_de", {31'b0, de}, 32'd1);
        check("pixel_7_4", {8'b0, red, green, blue}, 32'h070403);
        aresetn = 1'b0;
        i_start = 1'b1;
        tick();
        check("midreset_de", {31'b0, de}, 32'd0);
        check("midreset_rgb", {8'b0, red, green, blue}, 32'h0);
        aresetn = 1'b1;
        i_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (de || {red, green, blue} != 24'h0) bad++;
        end
        check("post_reset_idle", bad, 32'd0);

        // Restart with start held for 20 cycles: timing counts from the first edge.
        i_start = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            if (de) bad++;
            tick();
        end
        i_start = 1'b0;
        check("held_start_early_de", bad, 32'd0);
        wait_de(19, k);
        check("restart_latency", k, 32'd510);

        // Default 800x480 geometry: H_TOTAL=1056, first DE after 23*1056+46 edges.
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        repeat (24333) tick();
        check("dflt_pre_de", {31'b0, d_de}, 32'd0);
        tick();
        check("dflt_first_de", {31'b0, d_de}, 32'd1);
        check("dflt_pixel_0_0", {8'b0, d_red, d_green, d_blue}, 32'h0);
        repeat (10860) tick();
        check("dflt_pixel_300_10_de", {31'b0, d_de}, 32'd1);
        check("dflt_pixel_300_10", {8'b0, d_red, d_green, d_blue}, 32'h2C0A26);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
